// File: rtl/vrf_sched_pkg.sv
// Shared types for the VRF read-port scheduler.
//   VS_W/OFS_W/SRC_W/IDX_W : field widths of one VRF read request
//   vrf_read_req_t         : one read request {vs, offset, readSource, instructionIndex}
package vrf_sched_pkg;
  localparam int VS_W  = 5;
  localparam int OFS_W = 9;
  localparam int SRC_W = 2;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic [VS_W-1:0]  vs;
    logic [OFS_W-1:0] offset;
    logic [SRC_W-1:0] readSource;
    logic [IDX_W-1:0] instructionIndex;
  } vrf_read_req_t;
endpackage

// File: rtl/vrf_read_port_scheduler_rr_age_arbiter.sv
// Round-robin arbiter with starvation-age override and stall lock.
// Ports:
//   clock, reset   : clock, synchronous active-high reset
//   req_valid_i    : per-requester request valid
//   vrf_ready_i    : VRF accepts the granted request this cycle
//   grant_o        : one-hot (or zero) grant
//   fire_o         : granted request accepted by the VRF this cycle
module rr_age_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int STARVE_LIMIT = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic               vrf_ready_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               fire_o
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]              ptr_q, ptr_d;
  logic [PTR_W-1:0]              lock_idx_q, lock_idx_d;
  logic                          lock_q, lock_d;
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             starve_hit;

  // Grant: lock > starved (lowest index) > round-robin from pointer.
  // Loops run high-to-low so the lowest qualifying index wins last.
  always_comb begin
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    starve_hit = 1'b0;
    if (lock_q && req_valid_i[lock_idx_q]) begin
      gnt_any = 1'b1;
      gnt_idx = lock_idx_q;
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid_i[i] && cnt_q[i] == CNT_MAX) begin
          starve_hit = 1'b1;
          gnt_idx    = PTR_W'(i);
        end
      end
      if (starve_hit) begin
        gnt_any = 1'b1;
      end else begin
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          if (req_valid_i[(int'(ptr_q) + k) % NUM_REQ]) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
          end
        end
      end
    end
    grant_o = '0;
    if (gnt_any) grant_o[gnt_idx] = 1'b1;
  end

  assign fire_o = gnt_any & vrf_ready_i;

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    cnt_d      = cnt_q;

    if (fire_o) ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);

    // A stalled grant is pinned so index and fields stay stable until fire.
    // Dropping the locked requester's valid releases the lock defensively.
    if (fire_o) begin
      lock_d = 1'b0;
    end else if (gnt_any && !vrf_ready_i) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end else if (lock_q && !req_valid_i[lock_idx_q]) begin
      lock_d = 1'b0;
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_valid_i[i] || (fire_o && grant_o[i])) cnt_d[i] = '0;
      else if (cnt_q[i] != CNT_MAX)                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: rtl/vrf_read_port_scheduler.sv
// Shares one VRF bank read port among NUM_REQ read pipes and routes the read
// data back to the winner READ_LATENCY cycles after the request fires.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   req_*                 : per-requester valid/ready and packed request fields
//   vrf_*                 : muxed request to the VRF port, vrf_read_data return
//   resp_valid/resp_data  : one-hot response strobe, broadcast read data
//   busy                  : request presented or any response still in flight
module vrf_read_port_scheduler
  import vrf_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 7,
  parameter int DATA_W       = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*VS_W-1:0]  req_vs,
  input  logic [NUM_REQ*OFS_W-1:0] req_offset,
  input  logic [NUM_REQ*SRC_W-1:0] req_readSource,
  input  logic [NUM_REQ*IDX_W-1:0] req_instructionIndex,
  output logic                     vrf_valid,
  input  logic                     vrf_ready,
  output logic [VS_W-1:0]          vrf_vs,
  output logic [OFS_W-1:0]         vrf_offset,
  output logic [SRC_W-1:0]         vrf_readSource,
  output logic [IDX_W-1:0]         vrf_instructionIndex,
  input  logic [DATA_W-1:0]        vrf_read_data,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     busy
);
  logic [NUM_REQ-1:0]                     grant;
  logic                                   fire;
  vrf_read_req_t [NUM_REQ-1:0]            req_arr;
  vrf_read_req_t                          req_sel;
  logic [READ_LATENCY-1:0][NUM_REQ-1:0]   tag_pipe_q;

  rr_age_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clock       (clock),
    .reset       (reset),
    .req_valid_i (req_valid),
    .vrf_ready_i (vrf_ready),
    .grant_o     (grant),
    .fire_o      (fire)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_arr[g] = {req_vs[g*VS_W +: VS_W], req_offset[g*OFS_W +: OFS_W],
                         req_readSource[g*SRC_W +: SRC_W],
                         req_instructionIndex[g*IDX_W +: IDX_W]};
  end

  always_comb begin
    req_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) req_sel = req_arr[i];
    end
  end

  assign vrf_valid            = |grant;
  assign req_ready            = grant & {NUM_REQ{vrf_ready}};
  assign vrf_vs               = req_sel.vs;
  assign vrf_offset           = req_sel.offset;
  assign vrf_readSource       = req_sel.readSource;
  assign vrf_instructionIndex = req_sel.instructionIndex;

  // One-hot tag follows each fired request; the VRF has fixed latency so the
  // pipe never stalls and responses come back in issue order.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_pipe_q <= '0;
    end else begin
      tag_pipe_q[0] <= grant & {NUM_REQ{fire}};
      for (int s = 1; s < READ_LATENCY; s++) tag_pipe_q[s] <= tag_pipe_q[s-1];
    end
  end

  assign resp_valid = tag_pipe_q[READ_LATENCY-1];
  assign resp_data  = vrf_read_data;
  assign busy       = vrf_valid | (|tag_pipe_q);
endmodule

// File: tb/tb_vrf_read_port_scheduler.sv
module tb_vrf_read_port_scheduler;
  typedef struct {
    int          due;
    logic [3:0]  oh;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // DUT A: NUM_REQ=4, READ_LATENCY=2
  logic [3:0]  a_valid = '0, a_ready, a_resp;
  logic [19:0] a_vs = '0;
  logic [35:0] a_ofs = '0;
  logic [7:0]  a_src = '0;
  logic [11:0] a_idx = '0;
  logic        a_vready = 1'b0, a_vvalid, a_busy;
  logic [4:0]  a_ovs;
  logic [8:0]  a_oofs;
  logic [1:0]  a_osrc;
  logic [2:0]  a_oidx;
  logic [31:0] a_rdata;

  // DUT B: NUM_REQ=2, READ_LATENCY=4
  logic [1:0]  b_valid = '0, b_ready, b_resp;
  logic [9:0]  b_vs = '0;
  logic [17:0] b_ofs = '0;
  logic [3:0]  b_src = '0;
  logic [5:0]  b_idx = '0;
  logic        b_vready = 1'b0, b_vvalid, b_busy;
  logic [4:0]  b_ovs;
  logic [8:0]  b_oofs;
  logic [1:0]  b_osrc;
  logic [2:0]  b_oidx;
  logic [31:0] b_rdata;

  int          cyc = 0;
  int          ncmp = 0;
  int          nerr = 0;
  logic        dead = 1'b0;
  logic [31:0] rd_data;
  exp_t        qa[$];
  exp_t        qb[$];

  logic [4:0] tvs[4];
  logic [8:0] tofs[4];
  logic [1:0] tsrc[4];
  logic [2:0] tidx[4];

  always_comb rd_data = dead ? 32'hDEADBEEF : (32'h5A5A0000 ^ 32'(cyc));

  vrf_read_port_scheduler #(.NUM_REQ(4), .READ_LATENCY(2), .STARVE_LIMIT(7), .DATA_W(32)) dut_a (
    .clock(clock), .reset(reset), .req_valid(a_valid), .req_ready(a_ready),
    .req_vs(a_vs), .req_offset(a_ofs), .req_readSource(a_src), .req_instructionIndex(a_idx),
    .vrf_valid(a_vvalid), .vrf_ready(a_vready), .vrf_vs(a_ovs), .vrf_offset(a_oofs),
    .vrf_readSource(a_osrc), .vrf_instructionIndex(a_oidx), .vrf_read_data(rd_data),
    .resp_valid(a_resp), .resp_data(a_rdata), .busy(a_busy));

  vrf_read_port_scheduler #(.NUM_REQ(2), .READ_LATENCY(4), .STARVE_LIMIT(7), .DATA_W(32)) dut_b (
    .clock(clock), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_vs(b_vs), .req_offset(b_ofs), .req_readSource(b_src), .req_instructionIndex(b_idx),
    .vrf_valid(b_vvalid), .vrf_ready(b_vready), .vrf_vs(b_ovs), .vrf_offset(b_oofs),
    .vrf_readSource(b_osrc), .vrf_instructionIndex(b_oidx), .vrf_read_data(rd_data),
    .resp_valid(b_resp), .resp_data(b_rdata), .busy(b_busy));

  // Response scoreboard: every strobe must match the oldest expected entry.
  always @(posedge clock) begin
    exp_t e;
    cyc <= cyc + 1;
    #4;
    while (qa.size() > 0 && qa[0].due < cyc) begin
      e = qa.pop_front();
      ncmp++; nerr++;
      $display("FAIL respA_missed due=%0d now=%0d oh=%b", e.due, cyc, e.oh);
    end
    if (a_resp !== 4'b0000) begin
      ncmp++;
      if (qa.size() == 0) begin
        nerr++;
        $display("FAIL respA_unexpected cyc=%0d resp_valid=%b", cyc, a_resp);
      end else begin
        e = qa.pop_front();
        if (a_resp !== e.oh || a_rdata !== e.data || cyc != e.due) begin
          nerr++;
          $display("FAIL respA cyc=%0d got %b/%h, want %b/%h at cyc %0d", cyc, a_resp, a_rdata, e.oh, e.data, e.due);
        end
      end
    end
    while (qb.size() > 0 && qb[0].due < cyc) begin
      e = qb.pop_front();
      ncmp++; nerr++;
      $display("FAIL respB_missed due=%0d now=%0d oh=%b", e.due, cyc, e.oh);
    end
    if (b_resp !== 2'b00) begin
      ncmp++;
      if (qb.size() == 0) begin
        nerr++;
        $display("FAIL respB_unexpected cyc=%0d resp_valid=%b", cyc, b_resp);
      end else begin
        e = qb.pop_front();
        if ({2'b00, b_resp} !== e.oh || b_rdata !== e.data || cyc != e.due) begin
          nerr++;
          $display("FAIL respB cyc=%0d got %b/%h, want %b/%h at cyc %0d", cyc, b_resp, b_rdata, e.oh, e.data, e.due);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_field(input int i, input logic [4:0] vs, input logic [8:0] o,
                           input logic [1:0] s, input logic [2:0] x);
    tvs[i] = vs; tofs[i] = o; tsrc[i] = s; tidx[i] = x;
    a_vs[i*5 +: 5] = vs; a_ofs[i*9 +: 9] = o; a_src[i*2 +: 2] = s; a_idx[i*3 +: 3] = x;
  endtask

  task automatic pulse_reset;
    tick; reset = 1'b1;
    tick; reset = 1'b0;
  endtask

  task automatic test_reset;
    tick; tick; #2;
    ncmp++;
    if (a_ready !== 4'b0 || a_vvalid !== 1'b0 || a_resp !== 4'b0 || a_busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_a ready=%b vvalid=%b resp=%b busy=%b, want all 0", a_ready, a_vvalid, a_resp, a_busy);
    end
    ncmp++;
    if (b_ready !== 2'b0 || b_vvalid !== 1'b0 || b_resp !== 2'b0 || b_busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_b ready=%b vvalid=%b resp=%b busy=%b, want all 0", b_ready, b_vvalid, b_resp, b_busy);
    end
    tick; reset = 1'b0;
  endtask

  task automatic test_single;
    tick;
    dead = 1'b1;
    set_field(2, 5'd9, 9'h1A3, 2'd2, 3'd5);
    a_valid = 4'b0100; a_vready = 1'b1;
    #2;
    ncmp++;
    if (a_vvalid !== 1'b1 || a_ready !== 4'b0100) begin
      nerr++;
      $display("FAIL single_grant vvalid=%b ready=%b, want 1/0100", a_vvalid, a_ready);
    end
    ncmp++;
    if (a_ovs !== 5'd9 || a_oofs !== 9'h1A3 || a_osrc !== 2'd2 || a_oidx !== 3'd5) begin
      nerr++;
      $display("FAIL single_fields got %0d/%h/%0d/%0d, want 9/1a3/2/5", a_ovs, a_oofs, a_osrc, a_oidx);
    end
    qa.push_back('{due: cyc + 2, oh: 4'b0100, data: 32'hDEADBEEF});
    tick; a_valid = 4'b0; #2;
    ncmp++;
    if (a_busy !== 1'b1 || a_vvalid !== 1'b0 || a_resp !== 4'b0) begin
      nerr++;
      $display("FAIL single_inflight busy=%b vvalid=%b resp=%b, want 1/0/0000", a_busy, a_vvalid, a_resp);
    end
    tick; #2;
    ncmp++;
    if (a_resp !== 4'b0100 || a_rdata !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL single_resp got %b/%h, want 0100/deadbeef", a_resp, a_rdata);
    end
    tick; #2;
    ncmp++;
    if (a_busy !== 1'b0) begin
      nerr++;
      $display("FAIL single_idle busy=%b, want 0", a_busy);
    end
    dead = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [3:0] oh;
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      tick;
      a_valid = 4'hF; a_vready = 1'b1;
      #2;
      oh = 4'b0001 << (k % 4);
      ncmp++;
      if (a_ready !== oh || a_ovs !== tvs[k%4] || a_oofs !== tofs[k%4] || a_oidx !== tidx[k%4]) begin
        nerr++;
        $display("FAIL rr_grant k=%0d ready=%b vs=%0d, want %b vs=%0d", k, a_ready, a_ovs, oh, tvs[k%4]);
      end
      qa.push_back('{due: cyc + 2, oh: oh, data: 32'h5A5A0000 ^ 32'(cyc + 2)});
    end
    tick; a_valid = 4'b0;
    tick; tick;
  endtask

  task automatic test_stall_lock;
    for (int c = 0; c < 7; c++) begin
      tick;
      a_vready = (c >= 5);
      a_valid  = (c < 2) ? 4'b0010 : (c <= 5) ? 4'b0011 : 4'b0001;
      #2;
      ncmp++;
      if (c < 5) begin
        if (a_ready !== 4'b0 || a_vvalid !== 1'b1 || a_ovs !== tvs[1] || a_oofs !== tofs[1] || a_osrc !== tsrc[1]) begin
          nerr++;
          $display("FAIL stall_hold c=%0d ready=%b vvalid=%b vs=%0d, want 0000/1 vs=%0d", c, a_ready, a_vvalid, a_ovs, tvs[1]);
        end
      end else begin
        if (a_ready !== ((c == 5) ? 4'b0010 : 4'b0001)) begin
          nerr++;
          $display("FAIL stall_release c=%0d ready=%b, want %b", c, a_ready, (c == 5) ? 4'b0010 : 4'b0001);
        end
        qa.push_back('{due: cyc + 2, oh: (c == 5) ? 4'b0010 : 4'b0001, data: 32'h5A5A0000 ^ 32'(cyc + 2)});
      end
    end
    tick; a_valid = 4'b0;
    tick; tick;
  endtask

  task automatic test_starvation;
    logic [3:0] want;
    for (int c = 0; c < 13; c++) begin
      tick;
      a_vready = (c >= 9);
      if (c == 0)       a_valid = 4'b0001;
      else if (c <= 9)  a_valid = 4'b1001;
      else if (c <= 11) a_valid = 4'b1010;
      else              a_valid = 4'b1000;
      #2;
      ncmp++;
      if (c < 9) begin
        if (a_ready !== 4'b0 || a_vvalid !== 1'b1 || a_ovs !== tvs[0]) begin
          nerr++;
          $display("FAIL starve_lock c=%0d ready=%b vvalid=%b vs=%0d, want 0000/1 vs=%0d", c, a_ready, a_vvalid, a_ovs, tvs[0]);
        end
      end else begin
        case (c)
          9:       want = 4'b0001;
          10:      want = 4'b1000;
          11:      want = 4'b0010;
          default: want = 4'b1000;
        endcase
        if (a_ready !== want) begin
          nerr++;
          $display("FAIL starve_grant c=%0d ready=%b, want %b", c, a_ready, want);
        end
        qa.push_back('{due: cyc + 2, oh: want, data: 32'h5A5A0000 ^ 32'(cyc + 2)});
      end
    end
    tick; a_valid = 4'b0;
    tick; tick;
  endtask

  task automatic test_reset_midflight;
    tick;
    a_valid = 4'b0001; a_vready = 1'b1;
    #2;
    ncmp++;
    if (a_ready !== 4'b0001) begin
      nerr++;
      $display("FAIL rstmid_fire ready=%b, want 0001", a_ready);
    end
    tick; a_valid = 4'b0; reset = 1'b1;
    tick; reset = 1'b0; #2;
    ncmp++;
    if (a_resp !== 4'b0 || a_busy !== 1'b0 || a_vvalid !== 1'b0 || a_ready !== 4'b0) begin
      nerr++;
      $display("FAIL rstmid_after resp=%b busy=%b vvalid=%b ready=%b, want all 0", a_resp, a_busy, a_vvalid, a_ready);
    end
    tick; tick;
  endtask

  task automatic test_back_to_back;
    logic [1:0] oh;
    for (int k = 0; k < 6; k++) begin
      tick;
      b_valid = 2'b11; b_vready = 1'b1;
      #2;
      oh = 2'b01 << (k % 2);
      ncmp++;
      if (b_ready !== oh) begin
        nerr++;
        $display("FAIL b2b_grant k=%0d ready=%b, want %b", k, b_ready, oh);
      end
      qb.push_back('{due: cyc + 4, oh: {2'b00, oh}, data: 32'h5A5A0000 ^ 32'(cyc + 4)});
    end
    for (int k = 0; k < 6; k++) begin
      tick;
      b_valid = 2'b00;
      #2;
      ncmp++;
      if (b_busy !== (k < 4)) begin
        nerr++;
        $display("FAIL b2b_busy k=%0d busy=%b, want %b", k, b_busy, (k < 4));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      set_field(i, 5'(i + 16), 9'(9'h40 + i * 3), 2'(i), 3'(i + 1));
    test_reset();
    test_single();
    test_round_robin();
    test_stall_lock();
    test_starvation();
    test_reset_midflight();
    test_back_to_back();
    tick; tick; tick; tick;
    ncmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      nerr++;
      $display("FAIL drain pendingA=%0d pendingB=%0d, want 0/0", qa.size(), qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
